// File: rtl/duel_screen_controller_if.sv
// Command/event and display-select bundle between the game front end and the screen sequencer.
// Pure wiring: no latency of its own.
// No backpressure: inputs are one-cycle strobes, outputs are level selects held until the next frame.
interface duel_screen_controller_if;
  logic [31:0] ir_in;
  logic        ir_valid_in;
  logic        nf_in;
  logic        player_hit_in;
  logic        opponent_hit_in;
  logic [2:0]  state_out;
  logic        start_display_out;
  logic        play_active_out;
  logic [1:0]  countdown_out;
  logic        hit_flash_out;
  logic [3:0]  player_score_out;
  logic [3:0]  opponent_score_out;
  logic [1:0]  winner_out;

  // Front end: drives commands, frame pulses and hits; observes the selects
  modport master (
    output ir_in, ir_valid_in, nf_in, player_hit_in, opponent_hit_in,
    input  state_out, start_display_out, play_active_out, countdown_out,
           hit_flash_out, player_score_out, opponent_score_out, winner_out
  );

  // Sequencer: consumes commands and events, drives the display selects
  modport slave (
    input  ir_in, ir_valid_in, nf_in, player_hit_in, opponent_hit_in,
    output state_out, start_display_out, play_active_out, countdown_out,
           hit_flash_out, player_score_out, opponent_score_out, winner_out
  );
endinterface

// File: rtl/duel_screen_controller.sv
// Duel match sequencer: MENU -> COUNTDOWN -> PLAY -> POINT -> GAMEOVER, score keeping, display selects.
// Latency: visible outputs update on the clock edge that samples nf_in; events are latched until then.
// No backpressure: events between frames are collapsed into pending flags, cleared on every frame.
module duel_screen_controller #(
  parameter logic [31:0] START_CODE   = 32'h20DF_5BA4,
  parameter logic [31:0] MENU_CODE    = 32'h20DF_5AA5,
  parameter int          COUNT_FRAMES = 60,
  parameter int          POINT_FRAMES = 90,
  parameter int          WIN_SCORE    = 5
) (
  input logic               clk_in,
  input logic               rst_in,
  duel_screen_controller_if.slave bus
);

  localparam int MAXF = (COUNT_FRAMES > POINT_FRAMES) ? COUNT_FRAMES : POINT_FRAMES;
  localparam int CW   = (MAXF > 1) ? $clog2(MAXF) : 1;

  typedef enum logic [2:0] {
    S_MENU  = 3'd0,
    S_COUNT = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cd_q, cd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ps_q, ps_d, os_q, os_d;
  logic [1:0]    win_q, win_d;
  logic          start_q, play_q, flash_q;
  logic          pend_start_q, pend_start_d, pend_menu_q, pend_menu_d;
  logic          pend_ph_q, pend_ph_d, pend_oh_q, pend_oh_d;
  logic [3:0]    ps_inc, os_inc;

  // Event capture: a frame pulse clears all flags, events in that same cycle land for the next frame
  always_comb begin
    pend_start_d = bus.nf_in ? 1'b0 : pend_start_q;
    pend_menu_d  = bus.nf_in ? 1'b0 : pend_menu_q;
    pend_ph_d    = bus.nf_in ? 1'b0 : pend_ph_q;
    pend_oh_d    = bus.nf_in ? 1'b0 : pend_oh_q;
    if (bus.ir_valid_in && bus.ir_in == START_CODE) begin
      pend_start_d = 1'b1;
      pend_menu_d  = 1'b0;
    end else if (bus.ir_valid_in && bus.ir_in == MENU_CODE) begin
      pend_menu_d  = 1'b1;
      pend_start_d = 1'b0;
    end
    if (state_q == S_PLAY) begin
      if (bus.player_hit_in)   pend_ph_d = 1'b1;
      if (bus.opponent_hit_in) pend_oh_d = 1'b1;
    end
  end

  assign ps_inc = (ps_q == 4'd15) ? ps_q : ps_q + 4'd1;
  assign os_inc = (os_q == 4'd15) ? os_q : os_q + 4'd1;

  // Match transitions, evaluated only on a frame pulse so nothing changes mid-frame
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    ps_d    = ps_q;
    os_d    = os_q;
    win_d   = win_q;
    if (bus.nf_in) begin
      if (pend_menu_q) begin
        state_d = S_MENU;
        cd_d    = 2'd0;
        cnt_d   = '0;
        ps_d    = 4'd0;
        os_d    = 4'd0;
        win_d   = 2'd0;
      end else if (pend_start_q && (state_q == S_MENU || state_q == S_OVER)) begin
        state_d = S_COUNT;
        cd_d    = 2'd3;
        cnt_d   = '0;
        ps_d    = 4'd0;
        os_d    = 4'd0;
        win_d   = 2'd0;
      end else begin
        case (state_q)
          S_PLAY: begin
            if (pend_ph_q && pend_oh_q) begin
              // Double hit: nobody scores, but the exchange still freezes
              state_d = S_POINT;
              cnt_d   = '0;
            end else if (pend_ph_q) begin
              ps_d = ps_inc;
              if (ps_inc >= 4'(WIN_SCORE)) begin
                state_d = S_OVER;
                win_d   = 2'd1;
              end else begin
                state_d = S_POINT;
                cnt_d   = '0;
              end
            end else if (pend_oh_q) begin
              os_d = os_inc;
              if (os_inc >= 4'(WIN_SCORE)) begin
                state_d = S_OVER;
                win_d   = 2'd2;
              end else begin
                state_d = S_POINT;
                cnt_d   = '0;
              end
            end
          end
          S_COUNT: begin
            if (cnt_q == CW'(COUNT_FRAMES - 1)) begin
              cnt_d = '0;
              if (cd_q == 2'd1) begin
                state_d = S_PLAY;
                cd_d    = 2'd0;
              end else begin
                cd_d = cd_q - 2'd1;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          S_POINT: begin
            if (cnt_q == CW'(POINT_FRAMES - 1)) begin
              state_d = S_COUNT;
              cd_d    = 2'd3;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State, score and select registers; derived selects follow the next state so they never lag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_MENU;
      cd_q         <= 2'd0;
      cnt_q        <= '0;
      ps_q         <= 4'd0;
      os_q         <= 4'd0;
      win_q        <= 2'd0;
      start_q      <= 1'b1;
      play_q       <= 1'b0;
      flash_q      <= 1'b0;
      pend_start_q <= 1'b0;
      pend_menu_q  <= 1'b0;
      pend_ph_q    <= 1'b0;
      pend_oh_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      cnt_q        <= cnt_d;
      ps_q         <= ps_d;
      os_q         <= os_d;
      win_q        <= win_d;
      start_q      <= (state_d == S_MENU);
      play_q       <= (state_d == S_PLAY);
      flash_q      <= (state_d == S_POINT);
      pend_start_q <= pend_start_d;
      pend_menu_q  <= pend_menu_d;
      pend_ph_q    <= pend_ph_d;
      pend_oh_q    <= pend_oh_d;
    end
  end

  assign bus.state_out          = state_q;
  assign bus.start_display_out  = start_q;
  assign bus.play_active_out    = play_q;
  assign bus.countdown_out      = cd_q;
  assign bus.hit_flash_out      = flash_q;
  assign bus.player_score_out   = ps_q;
  assign bus.opponent_score_out = os_q;
  assign bus.winner_out         = win_q;

endmodule

// File: tb/tb_duel_screen_controller.sv
// Bench for the duel screen sequencer: directed match walk-through plus randomized traffic.
// Every cycle all outputs are compared with a frame-level model of the match rules.
// Inputs are applied just after a rising edge and outputs are sampled 1 time unit after the next one.
module tb_duel_screen_controller;

  localparam logic [31:0] START = 32'h20DF_5BA4;
  localparam logic [31:0] MENU  = 32'h20DF_5AA5;
  localparam int CF  = 2;
  localparam int PF  = 3;
  localparam int WIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  duel_screen_controller_if bus();

  duel_screen_controller #(
    .START_CODE(START), .MENU_CODE(MENU),
    .COUNT_FRAMES(CF), .POINT_FRAMES(PF), .WIN_SCORE(WIN)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  // Model: match phase (0 menu,1 countdown,2 play,3 point,4 over), digit, frames elapsed, scores
  int m_st, m_cd, m_fr, m_ps, m_os, m_win;
  bit q_start, q_menu, q_ph, q_oh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cd = 0; m_fr = 0; m_ps = 0; m_os = 0; m_win = 0;
    q_start = 0; q_menu = 0; q_ph = 0; q_oh = 0;
  endtask

  task automatic enter_countdown();
    m_st = 1; m_cd = 3; m_fr = 0;
  endtask

  task automatic model_step(input bit r, input bit iv, input logic [31:0] code,
                            input bit nf, input bit ph, input bit oh);
    int phase;
    if (r) begin
      model_reset();
      return;
    end
    phase = m_st;
    if (nf) begin
      if (q_menu) begin
        m_st = 0; m_cd = 0; m_fr = 0; m_ps = 0; m_os = 0; m_win = 0;
      end else if (q_start && (phase == 0 || phase == 4)) begin
        enter_countdown();
        m_ps = 0; m_os = 0; m_win = 0;
      end else if (phase == 2 && (q_ph || q_oh)) begin
        if (q_ph && q_oh) begin
          m_st = 3; m_fr = 0;
        end else begin
          if (q_ph) m_ps = (m_ps < 15) ? m_ps + 1 : 15;
          else      m_os = (m_os < 15) ? m_os + 1 : 15;
          if (m_ps >= WIN || m_os >= WIN) begin
            m_st = 4; m_win = (m_ps >= WIN) ? 1 : 2;
          end else begin
            m_st = 3; m_fr = 0;
          end
        end
      end else if (phase == 1) begin
        m_fr++;
        if (m_fr == CF) begin
          m_fr = 0;
          m_cd--;
          if (m_cd == 0) m_st = 2;
        end
      end else if (phase == 3) begin
        m_fr++;
        if (m_fr == PF) enter_countdown();
      end
      q_start = 0; q_menu = 0; q_ph = 0; q_oh = 0;
    end
    if (iv && code == START) begin q_start = 1; q_menu = 0; end
    if (iv && code == MENU)  begin q_menu = 1; q_start = 0; end
    if (phase == 2) begin
      if (ph) q_ph = 1;
      if (oh) q_oh = 1;
    end
  endtask

  task automatic compare_model();
    chk("state",  {29'd0, bus.state_out}, m_st);
    chk("start",  {31'd0, bus.start_display_out}, (m_st == 0) ? 1 : 0);
    chk("play",   {31'd0, bus.play_active_out}, (m_st == 2) ? 1 : 0);
    chk("flash",  {31'd0, bus.hit_flash_out}, (m_st == 3) ? 1 : 0);
    chk("cd",     {30'd0, bus.countdown_out}, (m_st == 1) ? m_cd : 0);
    chk("pscore", {28'd0, bus.player_score_out}, m_ps);
    chk("oscore", {28'd0, bus.opponent_score_out}, m_os);
    chk("winner", {30'd0, bus.winner_out}, (m_st == 4) ? m_win : 0);
  endtask

  // One clock with the given stimulus, then model update and full comparison
  task automatic cyc(input bit r, input bit iv, input logic [31:0] code,
                     input bit nf, input bit ph, input bit oh);
    rst                 = r;
    bus.ir_valid_in     = iv;
    bus.ir_in           = code;
    bus.nf_in           = nf;
    bus.player_hit_in   = ph;
    bus.opponent_hit_in = oh;
    @(posedge clk);
    model_step(r, iv, code, nf, ph, oh);
    #1;
    compare_model();
  endtask

  task automatic nfs(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'd0, 1, 0, 0);
  endtask

  task automatic ir(input logic [31:0] code);
    cyc(0, 1, code, 0, 0, 0);
  endtask

  task automatic hit(input bit ph, input bit oh);
    cyc(0, 0, 32'd0, 0, ph, oh);
  endtask

  task automatic countdown_to_play();
    int cdexp[6] = '{3, 2, 2, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      nfs(1);
      chk("cd_seq", {30'd0, bus.countdown_out}, cdexp[i]);
    end
    chk("to_play", {29'd0, bus.state_out}, 2);
  endtask

  initial begin
    bus.ir_in = 32'd0; bus.ir_valid_in = 0; bus.nf_in = 0;
    bus.player_hit_in = 0; bus.opponent_hit_in = 0;
    model_reset();
    cyc(1, 0, 32'd0, 0, 0, 0);
    cyc(1, 0, 32'd0, 0, 0, 0);
    chk("rst_state", {29'd0, bus.state_out}, 0);
    chk("rst_start", {31'd0, bus.start_display_out}, 1);

    // Start, countdown 3,3,2,2,1,1 then play
    ir(START); nfs(1);
    chk("cd_state", {29'd0, bus.state_out}, 1);
    chk("cd_start", {30'd0, bus.countdown_out}, 3);
    countdown_to_play();

    // Double hit: freeze without scoring
    hit(1, 1); nfs(1);
    chk("dbl_state", {29'd0, bus.state_out}, 3);
    chk("dbl_ps", {28'd0, bus.player_score_out}, 0);
    chk("dbl_os", {28'd0, bus.opponent_score_out}, 0);
    nfs(3);
    chk("pt_back", {29'd0, bus.state_out}, 1);
    countdown_to_play();

    // Single player hit
    hit(1, 0); nfs(1);
    chk("hit_ps", {28'd0, bus.player_score_out}, 1);
    chk("hit_st", {29'd0, bus.state_out}, 3);
    chk("hit_flash", {31'd0, bus.hit_flash_out}, 1);
    nfs(3);
    chk("pt_cd_st", {29'd0, bus.state_out}, 1);
    chk("pt_cd", {30'd0, bus.countdown_out}, 3);
    countdown_to_play();

    // Winning hit, then restart from game over
    hit(1, 0); nfs(1);
    chk("win_ps", {28'd0, bus.player_score_out}, 2);
    chk("win_st", {29'd0, bus.state_out}, 4);
    chk("win_who", {30'd0, bus.winner_out}, 1);
    ir(START); nfs(1);
    chk("rs_st", {29'd0, bus.state_out}, 1);
    chk("rs_ps", {28'd0, bus.player_score_out}, 0);
    chk("rs_win", {30'd0, bus.winner_out}, 0);
    countdown_to_play();

    // Unknown code and START in play are ignored
    ir(32'h20DF_0000); nfs(1);
    chk("bad_code", {29'd0, bus.state_out}, 2);
    ir(START); nfs(1);
    chk("start_play", {29'd0, bus.state_out}, 2);

    // Menu beats a pending hit
    hit(1, 0); ir(MENU); nfs(1);
    chk("menu_st", {29'd0, bus.state_out}, 0);
    chk("menu_disp", {31'd0, bus.start_display_out}, 1);
    chk("menu_ps", {28'd0, bus.player_score_out}, 0);

    // Hit during countdown is dropped
    ir(START); nfs(1);
    hit(1, 0); nfs(1);
    chk("cd_hit", {28'd0, bus.player_score_out}, 0);
    nfs(5);
    chk("cd_play", {29'd0, bus.state_out}, 2);

    // Reset mid-point at 1/1
    hit(1, 0); nfs(4); nfs(6);
    hit(0, 1); nfs(1);
    chk("pre_rst_os", {28'd0, bus.opponent_score_out}, 1);
    chk("pre_rst_st", {29'd0, bus.state_out}, 3);
    cyc(1, 0, 32'd0, 0, 0, 0);
    chk("mr_st", {29'd0, bus.state_out}, 0);
    chk("mr_ps", {28'd0, bus.player_score_out}, 0);
    chk("mr_os", {28'd0, bus.opponent_score_out}, 0);
    chk("mr_flash", {31'd0, bus.hit_flash_out}, 0);
    nfs(1);
    chk("mr_hold", {29'd0, bus.state_out}, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit r, iv, nf, ph, oh;
      logic [31:0] code;
      int sel;
      r   = ($urandom_range(0, 499) == 0);
      iv  = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 9);
      code = (sel < 5) ? START : (sel == 5) ? MENU : (sel == 6) ? 32'h20DF_0000 : $urandom;
      nf  = ($urandom_range(0, 2) == 0);
      ph  = ($urandom_range(0, 5) == 0);
      oh  = ($urandom_range(0, 5) == 0);
      cyc(r, iv, code, nf, ph, oh);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
